// File: rtl/bg_fill_responder.sv
// Worker-side background-fill responder: 4-phase start/done handshakes around
// a solid-colour fill of one frame-buffer region through a valid/ready port.
module bg_fill_responder #(
  parameter int unsigned WIDTH      = 800,
  parameter int unsigned HEIGHT     = 600,
  parameter int unsigned STRIDE     = 1024,
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bg_start,
  output logic                  bg_start_ack,
  output logic                  bg_done,
  input  logic                  bg_done_ack,
  input  logic [ADDR_WIDTH-1:0] frame_base,
  input  logic [DATA_WIDTH-1:0] color,
  output logic                  wr_valid,
  input  logic                  wr_ready,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  busy
);

  localparam int unsigned XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  typedef enum logic [2:0] {IDLE, START_ACK, FILL, DONE, DONE_WAIT} state_t;

  state_t                state, state_n;
  logic [XW-1:0]         x, x_n;
  logic [YW-1:0]         y, y_n;
  logic [ADDR_WIDTH-1:0] row_base, row_base_n;
  logic [DATA_WIDTH-1:0] col_reg, col_reg_n;
  logic                  start_ack_n, done_n, valid_n, busy_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [DATA_WIDTH-1:0] data_n;
  logic                  last_x, last_y;

  assign last_x = (x == XW'(WIDTH - 1));
  assign last_y = (y == YW'(HEIGHT - 1));

  // State and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      row_base     <= '0;
      col_reg      <= '0;
      bg_start_ack <= 1'b0;
      bg_done      <= 1'b0;
      wr_valid     <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_n;
      x            <= x_n;
      y            <= y_n;
      row_base     <= row_base_n;
      col_reg      <= col_reg_n;
      bg_start_ack <= start_ack_n;
      bg_done      <= done_n;
      wr_valid     <= valid_n;
      wr_addr      <= addr_n;
      wr_data      <= data_n;
      busy         <= busy_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    x_n         = x;
    y_n         = y;
    row_base_n  = row_base;
    col_reg_n   = col_reg;
    start_ack_n = bg_start_ack;
    done_n      = bg_done;
    valid_n     = wr_valid;
    addr_n      = wr_addr;
    data_n      = wr_data;

    unique case (state)
      IDLE: begin
        if (bg_start) begin
          col_reg_n   = color;
          row_base_n  = frame_base;
          x_n         = '0;
          y_n         = '0;
          start_ack_n = 1'b1;
          state_n     = START_ACK;
        end
      end
      START_ACK: begin
        if (!bg_start) begin
          start_ack_n = 1'b0;
          valid_n     = 1'b1;
          addr_n      = row_base;
          data_n      = col_reg;
          state_n     = FILL;
        end
      end
      FILL: begin
        if (wr_valid && wr_ready) begin
          if (last_x && last_y) begin
            valid_n = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else if (last_x) begin
            x_n        = '0;
            y_n        = y + YW'(1);
            row_base_n = row_base + ADDR_WIDTH'(STRIDE);
            addr_n     = row_base + ADDR_WIDTH'(STRIDE);
          end else begin
            x_n    = x + XW'(1);
            addr_n = wr_addr + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        if (bg_done_ack) begin
          done_n  = 1'b0;
          state_n = DONE_WAIT;
        end
      end
      DONE_WAIT: begin
        if (!bg_done_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule

// File: doc/bg_fill_responder.md
Name: bg_fill_responder

Overview:
- Worker-side end of the SwapController background handshake.
- Responds to bg_start/bg_start_ack and drives bg_done/bg_done_ack.
- Between those two handshakes it fills one frame-buffer region with a solid background colour through a valid/ready pixel-write port.
- Sits between SwapController and the frame-buffer write arbiter; the overlay engine uses an identical responder on ol_start/ol_done.

Parameters:
WIDTH, 800, pixels per line written
HEIGHT, 600, lines written
STRIDE, 1024, address distance between consecutive line starts (must be >= WIDTH)
ADDR_WIDTH, 20, width of wr_addr and frame_base
DATA_WIDTH, 32, width of wr_data and color

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
bg_start  in  1  start request from SwapController, 4-phase
bg_start_ack  out  1  start acknowledge, 4-phase
bg_done  out  1  fill-complete indication, 4-phase
bg_done_ack  in  1  done acknowledge from SwapController, 4-phase
frame_base  in  ADDR_WIDTH  base address of target buffer, sampled at start
color  in  DATA_WIDTH  fill value, sampled at start
wr_valid  out  1  pixel write request valid
wr_ready  in  1  arbiter accepts write this cycle
wr_addr  out  ADDR_WIDTH  pixel write address
wr_data  out  DATA_WIDTH  pixel write data
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered. Reset (async assert, sync-released use) forces state IDLE, counters x=y=0, and all outputs 0, including wr_addr and wr_data.
- States: IDLE, START_ACK, FILL, DONE, DONE_WAIT.
- IDLE: when bg_start=1 at an edge:
  - Latch frame_base into base_reg and color into col_reg.
  - Clear x, y; set row_base=frame_base.
  - Go to START_ACK. bg_start_ack=1 from that edge, so there is 1 cycle of latency from start seen to ack.
- START_ACK: bg_start_ack held 1 while bg_start=1. When bg_start=0 at an edge:
  - bg_start_ack->0, go to FILL.
  - wr_valid->1, wr_addr=row_base, wr_data=col_reg on the same edge.
- FILL:
  - wr_valid stays 1. wr_addr and wr_data must remain stable while wr_ready=0; valid never drops mid-transfer.
  - On each edge with wr_valid & wr_ready, advance one pixel:
    - If x<WIDTH-1: x+1, wr_addr+1.
    - Else x=0, y+1, row_base+=STRIDE, wr_addr=new row_base.
  - Address arithmetic is modulo 2^ADDR_WIDTH; wrap is permitted and not flagged.
  - Exactly WIDTH*HEIGHT beats are accepted. On acceptance of the beat with x=WIDTH-1, y=HEIGHT-1: wr_valid->0, bg_done->1, go to DONE.
- DONE: bg_done held 1 until bg_done_ack=1 at an edge, then bg_done->0 and go to DONE_WAIT.
- DONE_WAIT: when bg_done_ack=0, go to IDLE. A new start is accepted no earlier than the edge after IDLE is entered.
- Ignored inputs:
  - bg_start in FILL, DONE or DONE_WAIT is ignored; the controller cannot retrigger mid-fill.
  - bg_done_ack outside DONE/DONE_WAIT is ignored.
  - frame_base and color changes after the start edge have no effect.
- Simultaneous events: in IDLE, bg_start=1 together with stale bg_done_ack=1 still starts; ack is ignored.
- Reset mid-FILL: wr_valid drops asynchronously, no done is issued, and the partial fill is abandoned.
- WIDTH=1 or HEIGHT=1 must work; the last-beat detection uses both counters.

Test Plan:
Use WIDTH=4, HEIGHT=2, STRIDE=8, ADDR_WIDTH=12, DATA_WIDTH=32.
- Reset: assert reset mid-cycle -> all outputs 0 immediately. Release, then hold bg_start=0 for 5 cycles -> state stays IDLE, busy=0.
- Start handshake: frame_base=0x100, color=0x00FF00FF, bg_start=1 -> bg_start_ack=1 one edge later, held while bg_start=1. Drop bg_start -> ack=0 and wr_valid=1 with wr_addr=0x100 the same edge.
- Full fill, wr_ready=1 constantly -> 8 accepted beats with addrs 0x100-0x103, 0x108-0x10B, all data 0x00FF00FF. wr_valid=0 and bg_done=1 on the edge after beat 8.
- Backpressure: wr_ready toggles 1,0,0,1,... -> each address presented until accepted, no duplicate or skipped address, still exactly 8 beats.
- Done handshake: bg_done_ack=1 -> bg_done=0 next edge. Hold ack 3 cycles, with bg_start=1 asserted during them -> no new start_ack. Drop ack -> IDLE, then start accepted (start_ack=1) one edge later.
- Reset mid-fill: assert reset after beat 3 -> wr_valid=0, bg_done never asserted. Restart with frame_base=0xFFE -> addrs 0xFFE, 0xFFF, 0x000, 0x001 (wrap), then row 2 starting at 0x006.
